// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, fetch and data-memory waits.
// Optional perf counters (stall_cycles, flush_events) are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  localparam int unsigned WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           timeout_q;
  logic           mem_frozen;
  logic           load_use;

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (MEM_TIMEOUT != 0 && wait_cnt == TMO) begin
          state_nxt = ERR;
        end else if (wait_cnt < TMO) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The entry cycle (RUN with an unready access) already freezes the pipe.
  assign mem_frozen = !dmem_ready &&
                      ((state == MEM_WAIT) || (state == RUN && mem_req));

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) ||
                     (id_use_rs2 && id_rs2 == ex_rd));

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state == ERR) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      halted      = 1'b1;
    end else if (mem_frozen) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic redirect_evt;
  assign redirect_evt = !rst && (state != ERR) && !mem_frozen && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state != ERR) begin
      if (pc_stall)     stall_cycles <= stall_cycles + 1'b1;
      if (redirect_evt) flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule
